// File: rtl/road_scroll_ctrl_if.sv
// Control/status bundle between game logic, display timing and road_scroll_ctrl.
// Handshake: frame_start is a one-cycle strobe with no ready; the controller
// never back-pressures. step_pulse is a one-cycle strobe marking a new scroll_offset.
interface road_scroll_ctrl_if;
    logic [1:0]  level;
    logic        run;
    logic        crash;
    logic        frame_start;
    logic [9:0]  scroll_offset;
    logic        step_pulse;
    logic [15:0] distance;
    logic [1:0]  state;

    modport master (
        output level, run, crash, frame_start,
        input  scroll_offset, step_pulse, distance, state
    );

    modport slave (
        input  level, run, crash, frame_start,
        output scroll_offset, step_pulse, distance, state
    );
endinterface

// File: rtl/road_scroll_ctrl.sv
// Scrolling-road sequencer: level-driven scroll rate, frame-synchronous lane-dash
// offset update, IDLE/RUN/FREEZE state machine and a saturating distance odometer.
module road_scroll_ctrl #(
    parameter int DIV_COUNT   = 199999,
    parameter int STEP        = 8,
    parameter int LINE_PERIOD = 96
) (
    input  logic               clk,
    input  logic               reset_n,
    road_scroll_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam int DIV_W = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;

    state_t             state_q;
    logic [DIV_W-1:0]   base_cnt;
    logic [2:0]         sub_cnt;
    logic [2:0]         speed_q;
    logic               pending_q;
    logic [9:0]         offset_q;
    logic               pulse_q;
    logic [15:0]        dist_q;

    logic               stay_run;
    logic               base_tc;
    logic               tick;
    logic               apply;
    logic [10:0]        offset_sum;
    logic [9:0]         offset_wrap;

    function automatic logic [2:0] speed_of(input logic [1:0] lvl);
        return 3'd6 - {1'b0, lvl};
    endfunction

    // Counting and stepping happen only in cycles that remain in RUN, so a
    // frame_start coinciding with a RUN exit is dropped.
    assign stay_run    = (state_q == RUN) && bus.run && !bus.crash;
    assign base_tc     = (base_cnt == DIV_W'(DIV_COUNT));
    assign tick        = stay_run && base_tc && (sub_cnt == speed_q);
    assign apply       = stay_run && bus.frame_start && (pending_q || tick);
    assign offset_sum  = {1'b0, offset_q} + 11'(STEP);
    assign offset_wrap = 10'((offset_sum >= 11'(LINE_PERIOD)) ? offset_sum - 11'(LINE_PERIOD)
                                                               : offset_sum);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_cnt  <= '0;
            sub_cnt   <= '0;
            speed_q   <= 3'd6;
            pending_q <= 1'b0;
            offset_q  <= '0;
            pulse_q   <= 1'b0;
            dist_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    base_cnt  <= '0;
                    sub_cnt   <= '0;
                    pending_q <= 1'b0;
                    speed_q   <= speed_of(bus.level);
                    pulse_q   <= 1'b0;
                    if (bus.run) begin
                        state_q <= RUN;
                        dist_q  <= '0;
                    end
                end
                RUN: begin
                    pulse_q <= apply;
                    if (stay_run) begin
                        if (base_tc) begin
                            base_cnt <= '0;
                            // Speed is re-sampled only at a tick, so a period in progress
                            // always completes at the rate it started with.
                            if (sub_cnt == speed_q) begin
                                sub_cnt <= '0;
                                speed_q <= speed_of(bus.level);
                            end else begin
                                sub_cnt <= sub_cnt + 3'd1;
                            end
                        end else begin
                            base_cnt <= base_cnt + DIV_W'(1);
                        end
                    end
                    if (apply) begin
                        pending_q <= 1'b0;
                        offset_q  <= offset_wrap;
                        if (dist_q != 16'hFFFF) begin
                            dist_q <= dist_q + 16'd1;
                        end
                    end else if (tick) begin
                        pending_q <= 1'b1;
                    end
                    if (!bus.run) begin
                        state_q <= IDLE;
                    end else if (bus.crash) begin
                        state_q <= FREEZE;
                    end
                end
                FREEZE: begin
                    pulse_q <= 1'b0;
                    if (!bus.run) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pulse_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scroll_offset = offset_q;
    assign bus.step_pulse    = pulse_q;
    assign bus.distance      = dist_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_road_scroll_ctrl.sv
// Bench for road_scroll_ctrl: directed scenarios plus a random phase, all checked
// each cycle against a clock-count reference model of the scroll behaviour.
module tb_road_scroll_ctrl;

    localparam int DIV = 3;
    localparam int LP  = 96;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    road_scroll_ctrl_if bus();
    road_scroll_ctrl_if bus10();

    assign bus10.level       = bus.level;
    assign bus10.run         = bus.run;
    assign bus10.crash       = bus.crash;
    assign bus10.frame_start = bus.frame_start;

    road_scroll_ctrl #(.DIV_COUNT(DIV), .STEP(8), .LINE_PERIOD(LP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    road_scroll_ctrl #(.DIV_COUNT(DIV), .STEP(10), .LINE_PERIOD(LP)) dut10 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus10)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: tracks clocks elapsed in the current scroll period.
    int m_state, m_speed, m_elapsed, m_pending, m_off, m_off10, m_dist, m_pulse;
    int cyc = 0;
    int last_pulse_cyc = 0;
    int last_gap = 0;
    int npulse = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int spd(input int lvl);
        return 6 - lvl;
    endfunction

    task automatic model_reset();
        m_state = 0; m_speed = 6; m_elapsed = 0; m_pending = 0;
        m_off = 0; m_off10 = 0; m_dist = 0; m_pulse = 0;
    endtask

    task automatic model_edge(input int lvl, input bit r, input bit c, input bit f);
        bit stay, tick;
        m_pulse = 0;
        case (m_state)
            0: begin
                m_speed = spd(lvl); m_elapsed = 0; m_pending = 0;
                if (r) begin m_state = 1; m_dist = 0; end
            end
            1: begin
                stay = r && !c;
                tick = stay && (m_elapsed == (DIV + 1) * (m_speed + 1) - 1);
                if (tick) m_pending = 1;
                if (stay) begin
                    if (tick) begin m_elapsed = 0; m_speed = spd(lvl); end
                    else m_elapsed++;
                end
                if (stay && f && m_pending) begin
                    m_off   = (m_off + 8) % LP;
                    m_off10 = (m_off10 + 10) % LP;
                    if (m_dist < 65535) m_dist++;
                    m_pending = 0;
                    m_pulse = 1;
                end
                if (!r) m_state = 0;
                else if (c) m_state = 2;
            end
            default: if (!r) m_state = 0;
        endcase
    endtask

    task automatic cycle();
        int lvl; bit r, c, f, rn;
        lvl = int'(bus.level); r = bus.run; c = bus.crash; f = bus.frame_start; rn = reset_n;
        @(posedge clk);
        if (!rn) model_reset();
        else model_edge(lvl, r, c, f);
        cyc++;
        #1;
        chk("state",    32'(bus.state),           32'(m_state));
        chk("offset",   32'(bus.scroll_offset),   32'(m_off));
        chk("pulse",    32'(bus.step_pulse),      32'(m_pulse));
        chk("distance", 32'(bus.distance),        32'(m_dist));
        chk("offset10", 32'(bus10.scroll_offset), 32'(m_off10));
        chk("pulse10",  32'(bus10.step_pulse),    32'(m_pulse));
        if (bus.step_pulse === 1'b1) begin
            last_gap = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
            npulse++;
        end
    endtask

    task automatic run_until_pulse(input int budget, output int gap);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            if (bus.step_pulse === 1'b1) seen = 1;
        end
        chk("pulse_wait", 32'(seen), 32'd1);
        gap = last_gap;
    endtask

    initial begin
        int gap, off_s, dist_s, np_s;
        bus.level = 2'd0; bus.run = 1'b0; bus.crash = 1'b0; bus.frame_start = 1'b0;
        model_reset();

        // Reset and idle behaviour
        #1;
        chk("rst_offset", 32'(bus.scroll_offset), 32'd0);
        chk("rst_state",  32'(bus.state),         32'd0);
        chk("rst_pulse",  32'(bus.step_pulse),    32'd0);
        chk("rst_dist",   32'(bus.distance),      32'd0);
        repeat (3) cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.frame_start = 1'b1; cycle();
            bus.frame_start = 1'b0; cycle();
        end
        chk("idle_npulse", 32'(npulse), 32'd0);

        // Rate at level 3, frame_start every cycle
        bus.level = 2'd3; bus.run = 1'b1; bus.frame_start = 1'b1;
        run_until_pulse(40, gap);
        for (int i = 0; i < 11; i++) begin
            run_until_pulse(40, gap);
            chk("gap_l3", 32'(gap), 32'd16);
        end
        chk("wrap_offset", 32'(bus.scroll_offset),   32'd0);
        chk("wrap_dist",   32'(bus.distance),        32'd12);
        chk("wrap_off10",  32'(bus10.scroll_offset), 32'd24);

        // Switch to level 0: the period already latched still runs at speed 3
        bus.level = 2'd0;
        run_until_pulse(60, gap);
        chk("gap_l0_first", 32'(gap), 32'd16);
        for (int i = 0; i < 3; i++) begin
            run_until_pulse(60, gap);
            chk("gap_l0", 32'(gap), 32'd28);
        end

        // Level change halfway through a period
        repeat (14) cycle();
        bus.level = 2'd3;
        run_until_pulse(60, gap);
        chk("gap_mid_old", 32'(gap), 32'd28);
        for (int i = 0; i < 2; i++) begin
            run_until_pulse(60, gap);
            chk("gap_mid_new", 32'(gap), 32'd16);
        end

        // Frame sync: many ticks per frame collapse into one step
        bus.frame_start = 1'b0;
        off_s = m_off; np_s = npulse;
        for (int fr = 0; fr < 5; fr++) begin
            repeat (99) cycle();
            bus.frame_start = 1'b1;
            cycle();
            chk("frame_pulse", 32'(bus.step_pulse), 32'd1);
            bus.frame_start = 1'b0;
        end
        chk("frame_npulse", 32'(npulse - np_s), 32'd5);
        chk("frame_offset", 32'(bus.scroll_offset), 32'((off_s + 40) % LP));

        // Crash freezes everything until run drops
        bus.crash = 1'b1;
        cycle();
        chk("crash_state", 32'(bus.state), 32'd2);
        off_s = m_off; dist_s = m_dist;
        for (int i = 0; i < 200; i++) begin
            if (i == 20) bus.crash = 1'b0;
            bus.frame_start = (i % 10 == 0);
            cycle();
        end
        bus.frame_start = 1'b0;
        chk("freeze_state",  32'(bus.state),         32'd2);
        chk("freeze_offset", 32'(bus.scroll_offset), 32'(off_s));
        chk("freeze_dist",   32'(bus.distance),      32'(dist_s));
        bus.run = 1'b0; cycle();
        chk("freeze_exit", 32'(bus.state), 32'd0);
        bus.run = 1'b1; cycle();
        chk("rerun_state",  32'(bus.state),         32'd1);
        chk("rerun_dist",   32'(bus.distance),      32'd0);
        chk("rerun_offset", 32'(bus.scroll_offset), 32'(off_s));

        // run-low wins over crash in the same cycle
        repeat (5) cycle();
        bus.run = 1'b0; bus.crash = 1'b1; cycle();
        chk("prio_state", 32'(bus.state), 32'd0);
        bus.crash = 1'b0; bus.run = 1'b1;
        repeat (3) cycle();

        // Odometer saturation from a preloaded value
        force dut.dist_q = 16'hFFFE;
        m_dist = 16'hFFFE;
        cycle();
        release dut.dist_q;
        bus.frame_start = 1'b1;
        run_until_pulse(40, gap);
        chk("sat_first", 32'(bus.distance), 32'hFFFF);
        run_until_pulse(40, gap);
        chk("sat_hold", 32'(bus.distance), 32'hFFFF);
        bus.frame_start = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.run = ($urandom_range(0, 99) < 95);
            bus.crash = ($urandom_range(0, 199) < 2);
            bus.frame_start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) bus.level = 2'($urandom_range(0, 3));
            cycle();
        end

        // Asynchronous reset in the middle of a run
        bus.run = 1'b1; bus.crash = 1'b0; bus.frame_start = 1'b1; bus.level = 2'd3;
        repeat (40) cycle();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_state",  32'(bus.state),         32'd0);
        chk("arst_offset", 32'(bus.scroll_offset), 32'd0);
        chk("arst_dist",   32'(bus.distance),      32'd0);
        chk("arst_pulse",  32'(bus.step_pulse),    32'd0);
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (30) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
